// File: rtl/conv_pkg.sv
// Shared definitions for the 2x2 window generator and the downstream convolver.
// Holds the default image geometry, the pixel type and the packed window layout
// {p11, p10, p01, p00} where p00 is top-left and p1x is the bottom row.
package conv_pkg;

    localparam int IMG_W_DEF = 640;
    localparam int IMG_H_DEF = 360;
    localparam int PIX_W_DEF = 8;

    typedef logic [PIX_W_DEF-1:0] pixel_t;

    typedef struct packed {
        pixel_t p11;
        pixel_t p10;
        pixel_t p01;
        pixel_t p00;
    } win_t;

endpackage

// File: rtl/conv_line_buf.sv
// Half-row line buffer: IMG_W/2 entries, each holding one top-row pixel pair
// {top_right, top_left}. One synchronous write port and one asynchronous read port.
// Contents are not reset.
// Ports:
//   clk_i    clock
//   we_i     write enable
//   waddr_i  write address (column pair index)
//   wdata_i  write data {top_right, top_left}
//   raddr_i  read address (column pair index)
//   rdata_o  read data, combinational
module conv_line_buf #(
    parameter int DEPTH = 320,
    parameter int AW    = 9,
    parameter int DW    = 16
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/conv_window_gen.sv
// Raster-order pixel stream to non-overlapping 2x2 window converter.
// Even rows are paired up and parked in a half-row line buffer; on odd rows each
// odd-column pixel completes a tile and the window is registered for output.
// Optional feature macro: CONV_WIN_SOF_EN adds sof_i / frame_err_o.
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   valid_i, pixel_i         input pixel stream
//   ready_o                  input can be accepted (output register free or draining)
//   win_valid_o, win_ready_i output handshake
//   win_o                    {p11,p10,p01,p00}
//   win_first_o/win_last_o   first / last tile of the frame
//   sof_i, frame_err_o       (CONV_WIN_SOF_EN) start-of-frame force, sticky framing error
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               valid_i,
    input  logic [PIX_W-1:0]   pixel_i,
    output logic               ready_o,
    output logic               win_valid_o,
    input  logic               win_ready_i,
    output logic [4*PIX_W-1:0] win_o,
    output logic               win_first_o,
`ifdef CONV_WIN_SOF_EN
    input  logic               sof_i,
    output logic               frame_err_o,
`endif
    output logic               win_last_o
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int AW = CW - 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    if ((IMG_W % 2) != 0) begin : g_w_odd
        $error("conv_window_gen: IMG_W must be even");
    end
    if ((IMG_H % 2) != 0) begin : g_h_odd
        $error("conv_window_gen: IMG_H must be even");
    end

    logic [CW-1:0]      col_q, col_eff, col_d;
    logic [RW-1:0]      row_q, row_eff, row_d;
    logic [PIX_W-1:0]   held_q;
    logic               acc, lb_we, win_load;
    logic [2*PIX_W-1:0] lb_rdata;

    assign ready_o = !win_valid_o || win_ready_i;
    assign acc     = valid_i && ready_o;

    // Position of the pixel being accepted; sof_i overrides the counters.
`ifdef CONV_WIN_SOF_EN
    assign col_eff = sof_i ? '0 : col_q;
    assign row_eff = sof_i ? '0 : row_q;
`else
    assign col_eff = col_q;
    assign row_eff = row_q;
`endif

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (acc) begin
            if (col_eff == COL_LAST) begin
                col_d = '0;
                row_d = (row_eff == ROW_LAST) ? '0 : row_eff + 1'b1;
            end else begin
                col_d = col_eff + 1'b1;
                row_d = row_eff;
            end
        end
    end

    // Even row, odd col: park the top pair. Odd row, odd col: tile complete.
    assign lb_we    = acc && !row_eff[0] && col_eff[0];
    assign win_load = acc &&  row_eff[0] && col_eff[0];

    // Same column-pair address serves the write (even row) and read (odd row).
    conv_line_buf #(
        .DEPTH (IMG_W / 2),
        .AW    (AW),
        .DW    (2 * PIX_W)
    ) u_line_buf (
        .clk_i   (clk_i),
        .we_i    (lb_we),
        .waddr_i (col_eff[CW-1:1]),
        .wdata_i ({pixel_i, held_q}),
        .raddr_i (col_eff[CW-1:1]),
        .rdata_o (lb_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q       <= '0;
            row_q       <= '0;
            held_q      <= '0;
            win_valid_o <= 1'b0;
            win_o       <= '0;
            win_first_o <= 1'b0;
            win_last_o  <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            if (acc && !col_eff[0]) held_q <= pixel_i;
            if (win_load) begin
                win_o       <= {pixel_i, held_q, lb_rdata};
                win_first_o <= (row_eff == ROW_ONE)  && (col_eff == COL_ONE);
                win_last_o  <= (row_eff == ROW_LAST) && (col_eff == COL_LAST);
                win_valid_o <= 1'b1;
            end else if (win_ready_i) begin
                win_valid_o <= 1'b0;
            end
        end
    end

`ifdef CONV_WIN_SOF_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_err_o <= 1'b0;
        end else if (acc && sof_i && ((col_q != '0) || (row_q != '0))) begin
            frame_err_o <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
module tb_conv_window_gen;
    import conv_pkg::*;

    localparam int W = 4;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic [7:0]  pixel_i = '0;
    logic        ready_o;
    logic        win_valid_o;
    logic        win_ready_i = 1'b1;
    logic [31:0] win_o;
    logic        win_first_o;
    logic        win_last_o;
    logic        sof_i = 1'b0;
`ifdef CONV_WIN_SOF_EN
    logic        frame_err_o;
`endif

    always #5 clk = ~clk;

    conv_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .valid_i     (valid_i),
        .pixel_i     (pixel_i),
        .ready_o     (ready_o),
        .win_valid_o (win_valid_o),
        .win_ready_i (win_ready_i),
        .win_o       (win_o),
        .win_first_o (win_first_o),
`ifdef CONV_WIN_SOF_EN
        .sof_i       (sof_i),
        .frame_err_o (frame_err_o),
`endif
        .win_last_o  (win_last_o)
    );

    typedef struct { logic [31:0] win; logic first; logic last; } exp_t;
    typedef struct { win_t win; logic first; logic last; } vec_t;

    exp_t exp_q[$];
    exp_t obs_q[$];
    vec_t tv[4];
    int   checks = 0, errors = 0, nfirst = 0, nlast = 0;
    int   mcol = 0, mrow = 0;
    logic [7:0] fr [H][W];
    bit   mon_on = 1'b1;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    // Reference model: full-frame array, windows pushed when the bottom-right pixel is accepted.
    task automatic model_accept(input logic [7:0] p, input logic s);
        exp_t e;
        if (s) begin mcol = 0; mrow = 0; end
        fr[mrow][mcol] = p;
        if ((mrow % 2 == 1) && (mcol % 2 == 1)) begin
            e.win   = {fr[mrow][mcol], fr[mrow][mcol-1], fr[mrow-1][mcol], fr[mrow-1][mcol-1]};
            e.first = (mrow == 1) && (mcol == 1);
            e.last  = (mrow == H-1) && (mcol == W-1);
            exp_q.push_back(e);
        end
        if (mcol == W-1) begin
            mcol = 0;
            mrow = (mrow == H-1) ? 0 : mrow + 1;
        end else mcol++;
    endtask

    task automatic model_reset();
        mcol = 0; mrow = 0;
        exp_q.delete();
    endtask

    // Called at posedge+1; returns at posedge+1 after the pixel is taken.
    task automatic send(input logic [7:0] p, input logic s);
        int n = 0;
        valid_i = 1'b1; pixel_i = p; sof_i = s;
        @(negedge clk);
        while (!ready_o && n < 100) begin @(negedge clk); n++; end
        if (!ready_o) chk(1'b0, "send_timeout", 32'(n), 32'd100);
        else model_accept(p, s);
        @(posedge clk); #1;
        valid_i = 1'b0; sof_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
        chk(exp_q.size() == 0, "drain", 32'(exp_q.size()), 32'd0);
        idle(2);
    endtask

    task automatic check_tbl(input int base, input logic [7:0] off);
        win_t w;
        if (obs_q.size() < base + 4) begin
            chk(1'b0, "obs_count", 32'(obs_q.size()), 32'(base + 4));
            return;
        end
        for (int i = 0; i < 4; i++) begin
            w = tv[i].win;
            w.p00 = w.p00 + off; w.p01 = w.p01 + off;
            w.p10 = w.p10 + off; w.p11 = w.p11 + off;
            chk(obs_q[base+i].win == w, "tbl_win", obs_q[base+i].win, w);
            chk(obs_q[base+i].first == tv[i].first && obs_q[base+i].last == tv[i].last,
                "tbl_flags", {30'd0, obs_q[base+i].first, obs_q[base+i].last},
                {30'd0, tv[i].first, tv[i].last});
        end
    endtask

    // Output monitor: scoreboard compare on every output accept, stability during stalls.
    initial begin : monitor
        bit   stall = 1'b0;
        exp_t hold, cur, e;
        forever begin
            @(negedge clk);
            if (rst_ni && mon_on) begin
                if (stall)
                    chk(win_valid_o && win_o == hold.win && win_first_o == hold.first &&
                        win_last_o == hold.last, "hold_stable", win_o, hold.win);
                cur.win = win_o; cur.first = win_first_o; cur.last = win_last_o;
                stall = win_valid_o && !win_ready_i;
                hold  = cur;
                if (win_valid_o && win_ready_i) begin
                    obs_q.push_back(cur);
                    if (win_first_o) nfirst++;
                    if (win_last_o)  nlast++;
                    if (exp_q.size() == 0) chk(1'b0, "unexpected_win", win_o, 32'd0);
                    else begin
                        e = exp_q.pop_front();
                        chk(cur.win == e.win && cur.first == e.first && cur.last == e.last,
                            "scoreboard", {win_o[31:2], win_first_o, win_last_o},
                            {e.win[31:2], e.first, e.last});
                    end
                end
            end else stall = 1'b0;
        end
    end

    initial begin
        tv[0].win = {8'd5,  8'd4,  8'd1,  8'd0};  tv[0].first = 1'b1; tv[0].last = 1'b0;
        tv[1].win = {8'd7,  8'd6,  8'd3,  8'd2};  tv[1].first = 1'b0; tv[1].last = 1'b0;
        tv[2].win = {8'd13, 8'd12, 8'd9,  8'd8};  tv[2].first = 1'b0; tv[2].last = 1'b0;
        tv[3].win = {8'd15, 8'd14, 8'd11, 8'd10}; tv[3].first = 1'b0; tv[3].last = 1'b1;

        // Reset state
        #12;
        chk(!win_valid_o, "rst_valid", {31'd0, win_valid_o}, 32'd0);
        chk(win_o == '0, "rst_win", win_o, 32'd0);
        chk(!win_first_o && !win_last_o, "rst_flags", {30'd0, win_first_o, win_last_o}, 32'd0);
        chk(ready_o, "rst_ready", {31'd0, ready_o}, 32'd1);
        @(posedge clk); #1; rst_ni = 1'b1;
        idle(1);

        // 1: basic 4x4 frame
        obs_q.delete();
        for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
        drain();
        check_tbl(0, 8'd0);

        // 2: downstream stall at window 2
        obs_q.delete();
        fork
            begin
                for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
            end
            begin
                int n = 0;
                while (obs_q.size() < 1 && n < 100) begin @(negedge clk); n++; end
                @(posedge clk); #1; win_ready_i = 1'b0;
                n = 0;
                @(negedge clk);
                while (!win_valid_o && n < 20) begin @(negedge clk); n++; end
                for (int k = 0; k < 5; k++) begin
                    chk(!ready_o, "stall_ready", {31'd0, ready_o}, 32'd0);
                    chk(win_valid_o && win_o == tv[1].win, "stall_win", win_o, tv[1].win);
                    @(negedge clk);
                end
                @(posedge clk); #1; win_ready_i = 1'b1;
            end
        join
        drain();
        chk(obs_q.size() == 4, "stall_count", 32'(obs_q.size()), 32'd4);
        check_tbl(0, 8'd0);

        // 3: two frames back to back
        obs_q.delete();
        for (int i = 0; i < 32; i++) send(8'(i), 1'b0);
        drain();
        check_tbl(0, 8'd0);
        check_tbl(4, 8'd16);

        // 4: reset mid-frame
        obs_q.delete();
        for (int i = 0; i < 6; i++) send(8'(i), 1'b0);
        idle(3);
        rst_ni = 1'b0;
        model_reset();
        repeat (2) begin
            @(negedge clk);
            chk(!win_valid_o, "midrst_valid", {31'd0, win_valid_o}, 32'd0);
            chk(ready_o, "midrst_ready", {31'd0, ready_o}, 32'd1);
        end
        @(posedge clk); #1; rst_ni = 1'b1;
        obs_q.delete();
        for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
        drain();
        chk(obs_q.size() == 4, "rst_count", 32'(obs_q.size()), 32'd4);
        check_tbl(0, 8'd0);

        // 5: random pixels with random input gaps and output backpressure
        obs_q.delete(); nfirst = 0; nlast = 0;
        begin
            bit done = 1'b0;
            fork
                begin
                    for (int f = 0; f < 30; f++)
                        for (int i = 0; i < W*H; i++) begin
                            if ($urandom_range(3) == 0) idle($urandom_range(2, 1));
                            send(8'($urandom_range(255)), 1'b0);
                        end
                    done = 1'b1;
                end
                begin
                    while (!done) begin
                        @(posedge clk); #1;
                        win_ready_i = ($urandom_range(2) != 0);
                    end
                    win_ready_i = 1'b1;
                end
            join
        end
        drain();
        chk(obs_q.size() == 30 * (W/2) * (H/2), "rand_count", 32'(obs_q.size()), 32'(30*(W/2)*(H/2)));
        chk(nfirst == 30, "rand_first", 32'(nfirst), 32'd30);
        chk(nlast == 30, "rand_last", 32'(nlast), 32'd30);

`ifdef CONV_WIN_SOF_EN
        // 6: start-of-frame mid-row forces realignment
        obs_q.delete();
        chk(!frame_err_o, "sof_err_clr", {31'd0, frame_err_o}, 32'd0);
        for (int i = 0; i < 3; i++) send(8'(i), 1'b0);
        send(8'd3, 1'b1);
        chk(frame_err_o, "sof_err_set", {31'd0, frame_err_o}, 32'd1);
        for (int i = 4; i < 19; i++) send(8'(i), 1'b0);
        drain();
        chk(frame_err_o, "sof_err_sticky", {31'd0, frame_err_o}, 32'd1);
        chk(obs_q.size() == 4, "sof_count", 32'(obs_q.size()), 32'd4);
        if (obs_q.size() > 0)
            chk(obs_q[0].win == {8'd8, 8'd7, 8'd4, 8'd3} && obs_q[0].first, "sof_win0",
                obs_q[0].win, {8'd8, 8'd7, 8'd4, 8'd3});
`endif

        mon_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d want 0", 1);
        $fatal(1, "timeout");
    end

endmodule
